// File: rtl/ysyx_22041211_ifu.sv
// Decoupled instruction fetch unit: credit-limited request issue, in-order prefetch FIFO, redirect flush.
// Define YSYX_22041211_IFU_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module ysyx_22041211_ifu #(
    parameter int unsigned         ADDR_LEN   = 32,
    parameter int unsigned         DATA_LEN   = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned         FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid_i,
    input  logic [ADDR_LEN-1:0] redirect_target_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_req_addr_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_LEN-1:0] mem_rsp_data_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [DATA_LEN-1:0] inst_o,
    output logic [ADDR_LEN-1:0] inst_pc_o
);

    localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned    CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;

    // Tag FIFO: one PC per outstanding request, consumed in response order.
    logic [ADDR_LEN-1:0] tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    tag_wr_ptr_q, tag_rd_ptr_q;

    logic [ADDR_LEN-1:0] pc_mem   [FIFO_DEPTH];
    logic [DATA_LEN-1:0] inst_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                credit_ok;
    logic [CNT_W:0]      credit_used;
    logic                req_fire;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                bypass_take;
    logic [ADDR_LEN-1:0] rsp_pc;

    assign mem_req_addr_o = fetch_pc_q;
    assign credit_used    = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit_ok      = credit_used < DEPTH_C;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        outstanding_d   = outstanding_q;
        mem_req_valid_o = 1'b0;

        case (state_q)
            RUN:     mem_req_valid_o = credit_ok;
            FLUSH:   mem_req_valid_o = 1'b0;
            default: mem_req_valid_o = 1'b0;
        endcase
        if (rst) begin
            mem_req_valid_o = 1'b0;
        end
        req_fire = mem_req_valid_o & mem_req_ready_i;

        case ({req_fire, mem_rsp_valid_i})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid_i) begin
            fetch_pc_d = redirect_target_i;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
        end

        // A request accepted in the redirect cycle is already counted, so it keeps us in FLUSH.
        if (redirect_valid_i) begin
            state_d = (outstanding_d == '0) ? RUN : FLUSH;
        end else if (state_q == FLUSH && outstanding_d == '0) begin
            state_d = RUN;
        end
    end

    always_comb begin
        fifo_empty   = (count_q == '0);
        rsp_pc       = tag_mem[tag_rd_ptr_q];
        inst_valid_o = ~fifo_empty;
        inst_o       = fifo_empty ? '0 : inst_mem[rd_ptr_q];
        inst_pc_o    = fifo_empty ? '0 : pc_mem[rd_ptr_q];
        bypass_take  = 1'b0;
`ifdef YSYX_22041211_IFU_BYPASS_EN
        if (~rst && state_q == RUN && fifo_empty && mem_rsp_valid_i && ~redirect_valid_i) begin
            inst_valid_o = 1'b1;
            inst_o       = mem_rsp_data_i;
            inst_pc_o    = rsp_pc;
            bypass_take  = inst_ready_i;
        end
`endif
        pop  = ~fifo_empty & inst_ready_i;
        push = mem_rsp_valid_i & (state_q == RUN) & ~redirect_valid_i & ~bypass_take;

        if (redirect_valid_i) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            if (req_fire) begin
                tag_wr_ptr_q <= tag_wr_ptr_q + PTR_W'(1);
            end
            if (mem_rsp_valid_i) begin
                tag_rd_ptr_q <= tag_rd_ptr_q + PTR_W'(1);
            end
            if (redirect_valid_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_ptr_q] <= fetch_pc_q;
        end
        if (push) begin
            pc_mem[wr_ptr_q]   <= rsp_pc;
            inst_mem[wr_ptr_q] <= mem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Self-checking bench for ysyx_22041211_ifu: random memory/decode/redirect traffic against a queue-based
// model of the fetch stream, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ysyx_22041211_ifu;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    always #5 clk = ~clk;

    ysyx_22041211_ifu #(
        .ADDR_LEN  (32),
        .DATA_LEN  (32),
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_target_i(redirect_target_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_rsp_valid_i  (mem_rsp_valid_i),
        .mem_rsp_data_i   (mem_rsp_data_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o)
    );

    typedef struct { logic [31:0] addr; int cyc; } mreq_t;
    typedef struct { logic [31:0] pc; bit drop; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;

    mreq_t       mem_q[$];      // memory side: accepted requests awaiting a response
    flight_t     m_flight[$];   // model: outstanding requests, oldest first
    entry_t      m_fifo[$];     // model: buffered instructions, head first
    logic [31:0] m_pc = RST_PC;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acc  = 0;

    int          p_ready      = 100;
    int          p_rsp        = 100;
    int          p_inst_ready = 100;
    int          p_redirect   = 0;
    bit          force_redirect = 1'b0;
    logic [31:0] redirect_tgt   = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit m_flushing();
        foreach (m_flight[i]) if (m_flight[i].drop) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare DUT against the model, then advance the model and the memory with this cycle's inputs.
    always @(negedge clk) begin
        bit          exp_req;
        bit          exp_iv;
        bit          acc;
        bit          pop;
        flight_t     f;
        logic [31:0] hd_pc;
        logic [31:0] hd_data;
        if (rst) begin
            m_flight.delete();
            m_fifo.delete();
            mem_q.delete();
            m_pc = RST_PC;
        end else begin
            exp_req = !m_flushing() && (m_flight.size() + m_fifo.size() < DEPTH);
            exp_iv  = m_fifo.size() > 0;
            hd_pc   = exp_iv ? m_fifo[0].pc   : 32'h0;
            hd_data = exp_iv ? m_fifo[0].data : 32'h0;
            check("req_valid",  32'(mem_req_valid_o), 32'(exp_req));
            check("req_addr",   mem_req_addr_o, m_pc);
            check("inst_valid", 32'(inst_valid_o), 32'(exp_iv));
            check("inst",       inst_o, hd_data);
            check("inst_pc",    inst_pc_o, hd_pc);

            if (mem_req_valid_o && mem_req_ready_i) begin
                mem_q.push_back('{addr: mem_req_addr_o, cyc: cyc});
                n_acc++;
            end

            acc = exp_req && mem_req_ready_i;
            pop = exp_iv && inst_ready_i;
            if (pop) void'(m_fifo.pop_front());
            if (acc) begin
                m_flight.push_back('{pc: m_pc, drop: 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (mem_rsp_valid_i && m_flight.size() > 0) begin
                f = m_flight.pop_front();
                if (!f.drop && !redirect_valid_i) m_fifo.push_back('{pc: f.pc, data: mem_word(f.pc)});
            end
            if (redirect_valid_i) begin
                m_fifo.delete();
                foreach (m_flight[i]) m_flight[i].drop = 1'b1;
                m_pc = redirect_target_i;
            end
        end
        cyc++;
    end

    task automatic drive();
        mem_req_ready_i = ($urandom_range(0, 99) < p_ready);
        inst_ready_i    = ($urandom_range(0, 99) < p_inst_ready);
        if (force_redirect) begin
            redirect_valid_i  = 1'b1;
            redirect_target_i = redirect_tgt;
        end else if ($urandom_range(0, 99) < p_redirect) begin
            redirect_valid_i  = 1'b1;
            redirect_target_i = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h8000_0000)
                                + (32'($urandom_range(0, 63)) << 2);
        end else begin
            redirect_valid_i  = 1'b0;
            redirect_target_i = $urandom();
        end
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = $urandom();
        if (!rst && mem_q.size() > 0 && mem_q[0].cyc < cyc && $urandom_range(0, 99) < p_rsp) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
    endtask

    // Inputs change 1ns after the rising edge; directed checks look at +3ns, well before the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        #2;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        release_rst();
    endtask

    int acc0;

    initial begin
        rst               = 1'b1;
        redirect_valid_i  = 1'b0;
        redirect_target_i = 32'h0;
        mem_req_ready_i   = 1'b0;
        mem_rsp_valid_i   = 1'b0;
        mem_rsp_data_i    = 32'h0;
        inst_ready_i      = 1'b0;

        // Reset values, then a streaming fill with an always-ready 1-cycle memory.
        tick();
        tick();
        check("rst_req_valid",  32'(mem_req_valid_o), 32'd0);
        check("rst_req_addr",   mem_req_addr_o, 32'h8000_0000);
        check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst",       inst_o, 32'h0);
        check("rst_inst_pc",    inst_pc_o, 32'h0);
        release_rst();
        check("first_req_valid", 32'(mem_req_valid_o), 32'd1);
        check("first_req_addr",  mem_req_addr_o, 32'h8000_0000);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) begin
                check("fill_inst_valid", 32'(inst_valid_o), 32'd0);
            end else begin
                check("stream_inst_valid", 32'(inst_valid_o), 32'd1);
                check("stream_inst_pc",    inst_pc_o, 32'h8000_0000 + 32'(4 * (k - 2)));
            end
        end

        // Decode stalled: exactly FIFO_DEPTH requests go out, then credit is exhausted.
        p_inst_ready = 0;
        do_reset();
        acc0 = n_acc;
        repeat (10) tick();
        check("bp_accepts",    32'(n_acc - acc0), 32'd4);
        check("bp_req_valid",  32'(mem_req_valid_o), 32'd0);
        check("bp_inst_pc",    inst_pc_o, 32'h8000_0000);
        p_inst_ready = 100;
        tick();
        p_inst_ready = 0;
        tick();
        check("bp_credit_back", 32'(mem_req_valid_o), 32'd1);
        check("bp_next_pc",     inst_pc_o, 32'h8000_0004);

        // Redirect with 3 requests in flight: flush, drop all three, then fetch the target.
        p_inst_ready = 100;
        p_rsp        = 0;
        do_reset();
        tick();
        tick();
        p_ready        = 0;
        force_redirect = 1'b1;
        redirect_tgt   = 32'h8000_0100;
        tick();
        force_redirect = 1'b0;
        p_ready        = 100;
        tick();
        check("flush_req_valid",  32'(mem_req_valid_o), 32'd0);
        check("flush_inst_valid", 32'(inst_valid_o), 32'd0);
        p_rsp = 100;
        repeat (3) begin
            tick();
            check("drain_req_valid",  32'(mem_req_valid_o), 32'd0);
            check("drain_inst_valid", 32'(inst_valid_o), 32'd0);
        end
        tick();
        check("resume_req_valid", 32'(mem_req_valid_o), 32'd1);
        check("resume_req_addr",  mem_req_addr_o, 32'h8000_0100);
        tick();
        tick();
        check("resume_inst_valid", 32'(inst_valid_o), 32'd1);
        check("resume_inst_pc",    inst_pc_o, 32'h8000_0100);

        // Redirect in a cycle that also accepts a request and takes a response.
        do_reset();
        repeat (4) tick();
        force_redirect = 1'b1;
        redirect_tgt   = 32'h8000_0200;
        tick();
        force_redirect = 1'b0;
        tick();
        check("coin_req_valid",  32'(mem_req_valid_o), 32'd0);
        check("coin_inst_valid", 32'(inst_valid_o), 32'd0);
        tick();
        check("coin_req_addr",    mem_req_addr_o, 32'h8000_0200);
        check("coin_inst_valid2", 32'(inst_valid_o), 32'd0);
        tick();
        check("coin_inst_valid3", 32'(inst_valid_o), 32'd0);
        tick();
        check("coin_inst_pc",     inst_pc_o, 32'h8000_0200);

        // Redirect near the top of the address space: fetch PC wraps to zero.
        force_redirect = 1'b1;
        redirect_tgt   = 32'hFFFF_FFF8;
        do_reset();
        force_redirect = 1'b0;
        tick();
        check("wrap_flush_valid", 32'(mem_req_valid_o), 32'd0);
        tick();
        check("wrap_addr0", mem_req_addr_o, 32'hFFFF_FFF8);
        tick();
        check("wrap_addr1", mem_req_addr_o, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr2", mem_req_addr_o, 32'h0000_0000);
        check("wrap_inst_pc0", inst_pc_o, 32'hFFFF_FFF8);
        tick();
        tick();
        check("wrap_inst_pc2", inst_pc_o, 32'h0000_0000);

        // Reset asserted while flushing clears everything at once.
        p_rsp = 0;
        do_reset();
        tick();
        tick();
        force_redirect = 1'b1;
        redirect_tgt   = 32'h8000_0300;
        tick();
        force_redirect = 1'b0;
        tick();
        check("mid_flush_valid", 32'(mem_req_valid_o), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_req_valid",  32'(mem_req_valid_o), 32'd0);
        check("mid_rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check("mid_rst_req_addr",   mem_req_addr_o, 32'h8000_0000);
        tick();
        p_rsp = 100;
        release_rst();
        check("post_rst_req_valid", 32'(mem_req_valid_o), 32'd1);
        check("post_rst_req_addr",  mem_req_addr_o, 32'h8000_0000);
        tick();
        tick();
        check("post_rst_inst_pc", inst_pc_o, 32'h8000_0000);

        // Random traffic, checked every cycle by the model.
        p_redirect = 3;
        for (int blk = 0; blk < 30; blk++) begin
            p_ready      = $urandom_range(20, 100);
            p_rsp        = $urandom_range(10, 100);
            p_inst_ready = $urandom_range(0, 100);
            if (blk == 15) do_reset();
            repeat (100) tick();
        end
        p_redirect = 0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
